// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BUBBLE   = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A register dependency exists only for a real (non-$0) destination.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard detection between the load in EX and the
// instruction in ID.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       id_uses_rt,
  output logic       hz
);

  logic rs_hit_s;
  logic rt_hit_s;

  assign rs_hit_s = reg_match(id_ex_rt, if_id_rs);
  assign rt_hit_s = id_uses_rt & reg_match(id_ex_rt, if_id_rt);
  assign hz       = id_ex_mem_read & (rs_hit_s | rt_hit_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline register sequencer: stalls, flushes, memory-wait freeze
// and wait watchdog. Define HAZARD_PERF_CNT_EN to add stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT    = 255,
  parameter int unsigned LOADUSE_BUBBLES = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] IF_ID_RegisterRs,
  input  logic [4:0] IF_ID_RegisterRt,
  input  logic       ID_UsesRt,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_RegisterRt,
  input  logic       EX_Redirect,
  input  logic       IMEM_READY,
  input  logic       DMEM_BUSY,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Hold,
  output logic       ID_EX_Flush,
  output logic       BACK_Hold,
  output logic       BUS_ERR
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] STALL_CYCLES,
  output logic [15:0] FLUSH_EVENTS
`endif
);

  localparam int WCW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WCW-1:0] WT_L     = WCW'(WAIT_TIMEOUT);
  localparam logic [1:0]     BUB_INIT = 2'(LOADUSE_BUBBLES - 1);

  hz_state_e      state_r;
  hz_state_e      eff_state_s;
  logic [1:0]     bub_cnt_r;
  logic [1:0]     bub_dec_s;
  logic [WCW-1:0] wait_cnt_r;
  logic [WCW-1:0] wait_inc_s;
  logic           ret_bubble_r;
  logic           bus_err_r;
  logic           hz_s;
  logic           freeze_s;
  logic           redirect_act_s;
  logic           pc_write_s;
  logic           if_id_write_s;
  logic           if_id_flush_s;
  logic           id_ex_hold_s;
  logic           id_ex_flush_s;
  logic           back_hold_s;

  hazard_detect u_hazard_detect (
    .id_ex_mem_read (ID_EX_MemRead),
    .id_ex_rt       (ID_EX_RegisterRt),
    .if_id_rs       (IF_ID_RegisterRs),
    .if_id_rt       (IF_ID_RegisterRt),
    .id_uses_rt     (ID_UsesRt),
    .hz             (hz_s)
  );

  assign bub_dec_s  = bub_cnt_r - 2'd1;
  assign wait_inc_s = wait_cnt_r + WCW'(1);
  assign freeze_s   = (state_r == ERROR) | DMEM_BUSY;

  // Once the wait ends, the resume cycle behaves as the state that was interrupted.
  always_comb begin
    eff_state_s = state_r;
    case (state_r)
      MEM_WAIT: begin
        if (ret_bubble_r) begin
          eff_state_s = BUBBLE;
        end else begin
          eff_state_s = RUN;
        end
      end
      default: eff_state_s = state_r;
    endcase
  end

  // Sequencer state, bubble/wait counters and sticky watchdog error.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r      <= RUN;
      bub_cnt_r    <= 2'd0;
      wait_cnt_r   <= {WCW{1'b0}};
      ret_bubble_r <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      case (state_r)
        ERROR: begin
          state_r <= ERROR;
        end
        RUN, BUBBLE, MEM_WAIT: begin
          if (DMEM_BUSY) begin
            wait_cnt_r <= wait_inc_s;
            if (state_r != MEM_WAIT) begin
              ret_bubble_r <= (state_r == BUBBLE);
            end
            if (wait_inc_s == WT_L) begin
              state_r   <= ERROR;
              bus_err_r <= 1'b1;
            end else begin
              state_r <= MEM_WAIT;
            end
          end else begin
            wait_cnt_r <= {WCW{1'b0}};
            if (EX_Redirect) begin
              state_r   <= RUN;
              bub_cnt_r <= 2'd0;
            end else if (eff_state_s == BUBBLE) begin
              bub_cnt_r <= bub_dec_s;
              state_r   <= (bub_dec_s == 2'd0) ? RUN : BUBBLE;
            end else if (hz_s) begin
              bub_cnt_r <= BUB_INIT;
              state_r   <= (BUB_INIT == 2'd0) ? RUN : BUBBLE;
            end else begin
              state_r <= RUN;
            end
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  // Mealy control mux in priority order: reset, freeze, redirect, stall, fetch miss.
  always_comb begin
    pc_write_s     = 1'b1;
    if_id_write_s  = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_hold_s   = 1'b0;
    id_ex_flush_s  = 1'b0;
    back_hold_s    = 1'b0;
    redirect_act_s = 1'b0;
    if (!RST_N) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (freeze_s) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      id_ex_hold_s  = 1'b1;
      back_hold_s   = 1'b1;
    end else if (EX_Redirect) begin
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      redirect_act_s = 1'b1;
    end else if ((eff_state_s == BUBBLE) | hz_s) begin
      pc_write_s    = 1'b0;
      if_id_write_s = 1'b0;
      id_ex_flush_s = 1'b1;
    end else if (!IMEM_READY) begin
      pc_write_s    = 1'b0;
      if_id_flush_s = 1'b1;
    end else begin
      pc_write_s    = 1'b1;
      if_id_write_s = 1'b1;
    end
  end

  assign PCWrite     = pc_write_s;
  assign IF_ID_Write = if_id_write_s;
  assign IF_ID_Flush = if_id_flush_s;
  assign ID_EX_Hold  = id_ex_hold_s;
  assign ID_EX_Flush = id_ex_flush_s;
  assign BACK_Hold   = back_hold_s;
  assign BUS_ERR     = bus_err_r;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_r;
  logic [15:0] flush_events_r;

  // Saturating stall-cycle and redirect-flush event counters.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cycles_r <= 32'd0;
      flush_events_r <= 16'd0;
    end else begin
      if (!pc_write_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (redirect_act_s && (flush_events_r != 16'hFFFF)) begin
        flush_events_r <= flush_events_r + 16'd1;
      end else begin
        flush_events_r <= flush_events_r;
      end
    end
  end

  assign STALL_CYCLES = stall_cycles_r;
  assign FLUSH_EVENTS = flush_events_r;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl: one instance with a single
// load-use bubble and one with three, both with an 8-cycle memory-wait watchdog.
module tb_pipeline_hazard_ctrl;

  // Expected output vectors: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Hold, ID_EX_Flush, BACK_Hold, BUS_ERR}
  localparam logic [6:0] E_NORM   = 7'b1100000;
  localparam logic [6:0] E_STALL  = 7'b0000100;
  localparam logic [6:0] E_REDIR  = 7'b1110100;
  localparam logic [6:0] E_IMISS  = 7'b0110000;
  localparam logic [6:0] E_FREEZE = 7'b0001010;
  localparam logic [6:0] E_RESET  = 7'b0010100;
  localparam logic [6:0] E_ERRF   = 7'b0001011;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [4:0] rs, rt, ex_rt;
  logic       uses_rt, mem_read, redirect, imem_ready, dmem_busy;

  logic a_pcw, a_ifw, a_iff, a_idh, a_idf, a_bh, a_berr;
  logic b_pcw, b_ifw, b_iff, b_idh, b_idf, b_bh, b_berr;
  logic [6:0] a_vec, b_vec;

  int checks = 0;
  int errors = 0;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_stall, b_stall, stall0;
  logic [15:0] a_flush, b_flush, flush0;
`endif

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.WAIT_TIMEOUT(8), .LOADUSE_BUBBLES(1)) u_a (
    .CLK(CLK), .RST_N(rst_n),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .ID_UsesRt(uses_rt),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRt(ex_rt), .EX_Redirect(redirect),
    .IMEM_READY(imem_ready), .DMEM_BUSY(dmem_busy),
    .PCWrite(a_pcw), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_iff), .ID_EX_Hold(a_idh),
    .ID_EX_Flush(a_idf), .BACK_Hold(a_bh), .BUS_ERR(a_berr)
`ifdef HAZARD_PERF_CNT_EN
    , .STALL_CYCLES(a_stall), .FLUSH_EVENTS(a_flush)
`endif
  );

  pipeline_hazard_ctrl #(.WAIT_TIMEOUT(8), .LOADUSE_BUBBLES(3)) u_b (
    .CLK(CLK), .RST_N(rst_n),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .ID_UsesRt(uses_rt),
    .ID_EX_MemRead(mem_read), .ID_EX_RegisterRt(ex_rt), .EX_Redirect(redirect),
    .IMEM_READY(imem_ready), .DMEM_BUSY(dmem_busy),
    .PCWrite(b_pcw), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_iff), .ID_EX_Hold(b_idh),
    .ID_EX_Flush(b_idf), .BACK_Hold(b_bh), .BUS_ERR(b_berr)
`ifdef HAZARD_PERF_CNT_EN
    , .STALL_CYCLES(b_stall), .FLUSH_EVENTS(b_flush)
`endif
  );

  assign a_vec = {a_pcw, a_ifw, a_iff, a_idh, a_idf, a_bh, a_berr};
  assign b_vec = {b_pcw, b_ifw, b_iff, b_idh, b_idf, b_bh, b_berr};

  typedef struct {
    string      name;
    logic       rst_n;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       redirect;
    logic       imem_ready;
    logic       dmem_busy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mkv(input string nm, input logic r, input logic mr,
                               input logic [4:0] ert, input logic [4:0] s, input logic [4:0] t,
                               input logic u, input logic rd, input logic im, input logic bz,
                               input logic [6:0] e);
    vec_t v;
    v.name = nm; v.rst_n = r; v.mem_read = mr; v.ex_rt = ert; v.rs = s; v.rt = t;
    v.uses_rt = u; v.redirect = rd; v.imem_ready = im; v.dmem_busy = bz; v.exp = e;
    return v;
  endfunction

  task automatic set_idle();
    rst_n = 1'b1; mem_read = 1'b0; ex_rt = 5'd0; rs = 5'd1; rt = 5'd3;
    uses_rt = 1'b1; redirect = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_load_use();
    set_idle();
    mem_read = 1'b1; ex_rt = 5'd2; rs = 5'd2;
  endtask

  // Sample at the falling edge, mid-cycle; sel=0 checks u_a, sel=1 checks u_b.
  task automatic chk(input string nm, input bit sel, input logic [6:0] exp);
    logic [6:0] act;
    @(negedge CLK);
    act = sel ? b_vec : a_vec;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    next_cycle(); set_idle(); rst_n = 1'b0;
    chk("reset_a", 1'b0, {E_RESET[6:1], a_berr});
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b0;

    //           name           rst  mr  exrt   rs     rt     use  red  im   busy exp
    vecs[0]  = mkv("rst0",      0, 0, 5'd0, 5'd1, 5'd3, 1, 0, 1, 0, E_RESET);
    vecs[1]  = mkv("rst1",      0, 1, 5'd2, 5'd2, 5'd3, 1, 1, 0, 1, E_RESET);
    vecs[2]  = mkv("normal",    1, 0, 5'd0, 5'd1, 5'd3, 1, 0, 1, 0, E_NORM);
    vecs[3]  = mkv("lu_rs",     1, 1, 5'd2, 5'd2, 5'd3, 1, 0, 1, 0, E_STALL);
    vecs[4]  = mkv("after_lu",  1, 0, 5'd2, 5'd2, 5'd3, 1, 0, 1, 0, E_NORM);
    vecs[5]  = mkv("r0_filter", 1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 1, 0, E_NORM);
    vecs[6]  = mkv("rt_unused", 1, 1, 5'd5, 5'd3, 5'd5, 0, 0, 1, 0, E_NORM);
    vecs[7]  = mkv("lu_rt",     1, 1, 5'd5, 5'd3, 5'd5, 1, 0, 1, 0, E_STALL);
    vecs[8]  = mkv("redir_hz",  1, 1, 5'd2, 5'd2, 5'd3, 1, 1, 1, 0, E_REDIR);
    vecs[9]  = mkv("no_bubble", 1, 0, 5'd0, 5'd1, 5'd3, 1, 0, 1, 0, E_NORM);
    vecs[10] = mkv("imiss0",    1, 0, 5'd0, 5'd1, 5'd3, 1, 0, 0, 0, E_IMISS);
    vecs[11] = mkv("imiss1",    1, 0, 5'd0, 5'd1, 5'd3, 1, 0, 0, 0, E_IMISS);
    vecs[12] = mkv("imiss_end", 1, 0, 5'd0, 5'd1, 5'd3, 1, 0, 1, 0, E_NORM);
    vecs[13] = mkv("hz_vs_im",  1, 1, 5'd7, 5'd7, 5'd3, 1, 0, 0, 0, E_STALL);
    vecs[14] = mkv("busy_red",  1, 0, 5'd0, 5'd1, 5'd3, 1, 1, 1, 1, E_FREEZE);
    vecs[15] = mkv("busy2",     1, 0, 5'd0, 5'd1, 5'd3, 1, 1, 1, 1, E_FREEZE);
    vecs[16] = mkv("wait_red",  1, 0, 5'd0, 5'd1, 5'd3, 1, 1, 1, 0, E_REDIR);
    vecs[17] = mkv("post_wait", 1, 0, 5'd0, 5'd1, 5'd3, 1, 0, 1, 0, E_NORM);
    vecs[18] = mkv("rst_mid",   0, 1, 5'd4, 5'd4, 5'd3, 1, 0, 0, 0, E_RESET);
    vecs[19] = mkv("post_rst",  1, 0, 5'd0, 5'd1, 5'd3, 1, 0, 1, 0, E_NORM);

    for (int i = 0; i < 20; i++) begin
      next_cycle();
      rst_n = vecs[i].rst_n; mem_read = vecs[i].mem_read; ex_rt = vecs[i].ex_rt;
      rs = vecs[i].rs; rt = vecs[i].rt; uses_rt = vecs[i].uses_rt;
      redirect = vecs[i].redirect; imem_ready = vecs[i].imem_ready; dmem_busy = vecs[i].dmem_busy;
      chk(vecs[i].name, 1'b0, vecs[i].exp);
    end

    // Three bubbles per load-use hazard
    do_reset();
    next_cycle(); set_load_use(); chk("b3_lu", 1'b1, E_STALL);
    next_cycle(); set_idle();     chk("b3_bub1", 1'b1, E_STALL);
    next_cycle(); set_idle();     chk("b3_bub2", 1'b1, E_STALL);
    next_cycle(); set_idle();     chk("b3_done", 1'b1, E_NORM);

    // Redirect with two bubbles still pending cancels them
    next_cycle(); set_load_use(); chk("b3r_lu", 1'b1, E_STALL);
    next_cycle(); set_idle(); redirect = 1'b1; chk("b3r_redir", 1'b1, E_REDIR);
    next_cycle(); set_idle();     chk("b3r_run", 1'b1, E_NORM);

    // Four-cycle memory wait in the middle of the bubble sequence
    next_cycle(); set_load_use(); chk("bw_lu", 1'b1, E_STALL);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); set_idle(); dmem_busy = 1'b1; chk("bw_freeze", 1'b1, E_FREEZE);
    end
    next_cycle(); set_idle();     chk("bw_bub1", 1'b1, E_STALL);
    next_cycle(); set_idle();     chk("bw_bub2", 1'b1, E_STALL);
    next_cycle(); set_idle();     chk("bw_run", 1'b1, E_NORM);

    // Watchdog: eight busy cycles trip the 8-cycle timeout
    do_reset();
    for (int k = 0; k < 8; k++) begin
      next_cycle(); set_idle(); dmem_busy = 1'b1; chk("wd_busy", 1'b0, E_FREEZE);
    end
    next_cycle(); set_idle();                 chk("wd_err", 1'b0, E_ERRF);
    next_cycle(); set_idle(); redirect = 1'b1; chk("wd_err_red", 1'b0, E_ERRF);
    next_cycle(); set_load_use();             chk("wd_err_lu", 1'b0, E_ERRF);
    next_cycle(); set_idle(); rst_n = 1'b0;   chk("wd_rst", 1'b0, {E_RESET[6:1], 1'b1});
    next_cycle(); set_idle();                 chk("wd_clear", 1'b0, E_NORM);

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    next_cycle(); set_idle(); chk("pc_norm", 1'b0, E_NORM);
    stall0 = a_stall; flush0 = a_flush;
    next_cycle(); set_idle(); imem_ready = 1'b0; chk("pc_im0", 1'b0, E_IMISS);
    next_cycle(); set_idle(); imem_ready = 1'b0; chk("pc_im1", 1'b0, E_IMISS);
    next_cycle(); set_idle(); redirect = 1'b1;   chk("pc_red", 1'b0, E_REDIR);
    next_cycle(); set_idle();                    chk("pc_end", 1'b0, E_NORM);
    checks++;
    if (a_stall !== stall0 + 32'd2) begin
      errors++;
      $display("FAIL stall_cycles: got %0d expected %0d", a_stall, stall0 + 32'd2);
    end
    checks++;
    if (a_flush !== flush0 + 16'd1) begin
      errors++;
      $display("FAIL flush_events: got %0d expected %0d", a_flush, flush0 + 16'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-cycle write-enable, hold and flush controls for load-use stalls, EX-stage branch/jump redirects, instruction-fetch wait and multi-cycle data-memory wait.
- Contains an FSM and a wait-timeout watchdog. Sits beside the datapath and drives only control pins of the stage registers.

Parameters:
- WAIT_TIMEOUT, 255: max consecutive DMEM_BUSY cycles before BUS_ERR; legal range 1..65535.
- LOADUSE_BUBBLES, 1: bubbles inserted per load-use hazard; legal range 1..3.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- IF_ID_RegisterRs  in  5  rs of instruction in ID.
- IF_ID_RegisterRt  in  5  rt of instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt (R-type, store, beq/bne).
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegisterRt  in  5  load destination in EX.
- EX_Redirect  in  1  branch taken or jump resolved in EX.
- IMEM_READY  in  1  instruction fetch data valid this cycle.
- DMEM_BUSY  in  1  data memory not completing this cycle.
- PCWrite  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID load enable.
- IF_ID_Flush  out  1  IF/ID loads NOP.
- ID_EX_Hold  out  1  ID/EX keeps contents.
- ID_EX_Flush  out  1  ID/EX loads bubble (all controls 0).
- BACK_Hold  out  1  EX/MEM and MEM/WB keep contents.
- BUS_ERR  out  1  sticky watchdog error.

Behaviour:
- States: RUN, BUBBLE, MEM_WAIT, ERROR; 2-bit encoding. Bubble counter is 2-bit; wait counter is $clog2(WAIT_TIMEOUT+1) bits.
- Outputs are Mealy: combinational from state and inputs, so a response lands in the same cycle as its cause.
- Reset (RST_N=0 at edge): state=RUN, counters=0, BUS_ERR=0.
- While RST_N=0, outputs are PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Hold=0, ID_EX_Flush=1, BACK_Hold=0.
- Hazard: hz = ID_EX_MemRead & ID_EX_RegisterRt!=0 & (ID_EX_RegisterRt==IF_ID_RegisterRs | (ID_UsesRt & ID_EX_RegisterRt==IF_ID_RegisterRt)).
- Priority, highest first: ERROR > DMEM_BUSY > EX_Redirect > hz/BUBBLE > !IMEM_READY > normal.
- Freeze (ERROR, or DMEM_BUSY in any state): PCWrite=0, IF_ID_Write=0, ID_EX_Hold=1, BACK_Hold=1, both flushes 0.
- Redirect (no freeze): PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1. Pending bubbles are cancelled and state goes to RUN.
- Load-use (RUN & hz, no freeze/redirect): PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. Bubble count = LOADUSE_BUBBLES-1; if that count is nonzero, go to BUBBLE.
- BUBBLE: same outputs as load-use; count decrements each cycle; go to RUN when count reaches 0.
- IMEM not ready (no higher cause): PCWrite=0, IF_ID_Write=1, IF_ID_Flush=1, so a NOP enters the pipe.
- Normal: PCWrite=1, IF_ID_Write=1, all flushes and holds 0.
- MEM_WAIT: entered on DMEM_BUSY from RUN or BUBBLE; the return state is saved in a 1-bit register. The wait counter increments each busy cycle.
- Leaving MEM_WAIT: on the first cycle with DMEM_BUSY=0, the counter clears and the FSM resumes the saved state. The bubble count is preserved.
- Watchdog: counter reaching WAIT_TIMEOUT while DMEM_BUSY=1 moves the FSM to ERROR and sets BUS_ERR=1. ERROR exits only on reset.
- Simultaneous events:
  - Redirect with hz: redirect wins, no bubble.
  - DMEM_BUSY with redirect: freeze; the redirect stays visible in the frozen ID/EX and is acted on once busy drops.
- Reset mid-MEM_WAIT or mid-BUBBLE: immediate return to RUN at that edge.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs STALL_CYCLES[31:0] and FLUSH_EVENTS[15:0]. Each is cleared by reset and saturates at its maximum.
  - STALL_CYCLES increments on any cycle with PCWrite=0 while RST_N=1.
  - FLUSH_EVENTS increments once per redirect cycle.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds the state typedef/localparams (RUN=0, BUBBLE=1, MEM_WAIT=2, ERROR=3) and a REG_ZERO=5'd0 constant.
- One natural sub-module, hazard_detect: the purely combinational hz equation. The FSM, counters and output mux stay in the top module.

Test Plan:
- Load-use: lw $2 in EX with IF_ID_RegisterRs=2 -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, then normal. With LOADUSE_BUBBLES=3 the same outputs hold for 3 cycles.
- $0 and rt filtering: ID_EX_RegisterRt=0 -> no stall. ID_UsesRt=0 with a match only on rt -> no stall.
- Redirect plus hazard in the same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, no bubble follows. Redirect during BUBBLE (count 2 left) -> RUN on the next cycle.
- DMEM_BUSY held 4 cycles during BUBBLE -> all holds for 4 cycles, no state loss, remaining bubbles are then issued. Redirect asserted during the wait -> acted on in the first non-busy cycle.
- Watchdog: WAIT_TIMEOUT=8 with DMEM_BUSY held 8 cycles -> BUS_ERR=1 and permanent freeze. RST_N=0 for one edge -> BUS_ERR=0, state RUN.
- IMEM_READY=0 for 2 cycles -> PCWrite=0, IF_ID_Flush=1 for 2 cycles. With HAZARD_PERF_CNT_EN defined, STALL_CYCLES advances by exactly 2.
